// File: rtl/mig_arbiter.sv
// Read/write requester arbiter in front of a MIG native app interface.
// Optional build macro MIG_ARB_REFRESH_EN adds the periodic user-refresh generator and REF state.
module mig_arbiter #(
  parameter int ADDR_W          = 28,
  parameter int DATA_W          = 128,
  parameter int MAX_RD_RUN      = 8,
  parameter int MAX_OUTSTANDING = 16,
  parameter int REF_INTERVAL    = 780
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  init_calib_complete,
  input  logic                  rd_req,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic                  rd_ack,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  rd_valid,
  input  logic                  wr_req,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [DATA_W/8-1:0]   wr_mask,
  output logic                  wr_ack,
  output logic [ADDR_W-1:0]     app_addr,
  output logic [2:0]            app_cmd,
  output logic                  app_en,
  output logic [DATA_W-1:0]     app_wdf_data,
  output logic [DATA_W/8-1:0]   app_wdf_mask,
  output logic                  app_wdf_wren,
  output logic                  app_wdf_end,
  input  logic                  app_rdy,
  input  logic                  app_wdf_rdy,
  input  logic [DATA_W-1:0]     app_rd_data,
  input  logic                  app_rd_data_valid,
  output logic                  app_ref_req,
  input  logic                  app_ref_ack
);

  localparam int OW   = $clog2(MAX_OUTSTANDING + 1);
  localparam int RUNW = $clog2(MAX_RD_RUN + 1);
  localparam logic [OW-1:0]   OUT_MAX = OW'(MAX_OUTSTANDING);
  localparam logic [RUNW-1:0] RUN_MAX = RUNW'(MAX_RD_RUN);

`ifdef MIG_ARB_REFRESH_EN
  typedef enum logic [2:0] {INIT, IDLE, RD, WR, REF} state_t;
`else
  typedef enum logic [1:0] {INIT, IDLE, RD, WR} state_t;
`endif

  state_t                state_q, state_d;
  logic [RUNW-1:0]       rd_run_q, rd_run_d;
  logic [OW-1:0]         outst_q, outst_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [DATA_W/8-1:0]   wmask_q, wmask_d;
  logic                  cmd_done_q, cmd_done_d;
  logic                  wdf_done_q, wdf_done_d;
  logic [DATA_W-1:0]     rd_data_q;
  logic                  rd_valid_q;
  logic                  grant_rd, grant_wr, rd_accept;

`ifdef MIG_ARB_REFRESH_EN
  localparam int RW = $clog2(REF_INTERVAL + 1);
  logic [RW-1:0] ref_cnt_q, ref_cnt_d;
  logic          ref_pend_q, ref_pend_d;
  logic          ref_clr;
`else
  logic unused_ref;
  assign unused_ref  = app_ref_ack ^ (REF_INTERVAL != 0);
  assign app_ref_req = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    rd_run_d     = rd_run_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wmask_d      = wmask_q;
    cmd_done_d   = cmd_done_q;
    wdf_done_d   = wdf_done_q;
    grant_rd     = 1'b0;
    grant_wr     = 1'b0;
    rd_accept    = 1'b0;
    app_en       = 1'b0;
    app_cmd      = 3'b000;
    app_wdf_wren = 1'b0;
    rd_ack       = 1'b0;
    wr_ack       = 1'b0;
`ifdef MIG_ARB_REFRESH_EN
    ref_clr      = 1'b0;
    app_ref_req  = 1'b0;
`endif
    case (state_q)
      INIT: if (init_calib_complete) state_d = IDLE;
      IDLE: begin
        if (!init_calib_complete) state_d = INIT;
`ifdef MIG_ARB_REFRESH_EN
        else if (ref_pend_q) state_d = REF;
`endif
        // A write starved by a full read run beats any further reads.
        else if (wr_req && rd_run_q == RUN_MAX) grant_wr = 1'b1;
        else if (rd_req && outst_q < OUT_MAX) grant_rd = 1'b1;
        else if (wr_req) grant_wr = 1'b1;
      end
      RD: begin
        app_en  = 1'b1;
        app_cmd = 3'b001;
        if (app_rdy) begin
          rd_ack    = 1'b1;
          rd_accept = 1'b1;
          state_d   = init_calib_complete ? IDLE : INIT;
        end
      end
      WR: begin
        app_en       = !cmd_done_q;
        app_wdf_wren = !wdf_done_q;
        if (app_rdy)     cmd_done_d = 1'b1;
        if (app_wdf_rdy) wdf_done_d = 1'b1;
        // Command and data halves may finish in either order; ack once both are in.
        if ((cmd_done_q || app_rdy) && (wdf_done_q || app_wdf_rdy)) begin
          wr_ack     = 1'b1;
          cmd_done_d = 1'b0;
          wdf_done_d = 1'b0;
          state_d    = init_calib_complete ? IDLE : INIT;
        end
      end
`ifdef MIG_ARB_REFRESH_EN
      REF: begin
        app_ref_req = 1'b1;
        if (app_ref_ack) begin
          ref_clr = 1'b1;
          state_d = IDLE;
        end
      end
`endif
      default: state_d = INIT;
    endcase

    if (grant_rd) begin
      state_d = RD;
      addr_d  = rd_addr;
      if (rd_run_q != RUN_MAX) rd_run_d = rd_run_q + RUNW'(1);
    end
    if (grant_wr) begin
      state_d    = WR;
      addr_d     = wr_addr;
      wdata_d    = wr_data;
      wmask_d    = wr_mask;
      rd_run_d   = '0;
      cmd_done_d = 1'b0;
      wdf_done_d = 1'b0;
    end

    // Accept and return in the same cycle cancel; a stray return never underflows.
    outst_d = outst_q;
    if (rd_accept && !app_rd_data_valid) outst_d = outst_q + OW'(1);
    else if (!rd_accept && app_rd_data_valid && outst_q != '0) outst_d = outst_q - OW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= INIT;
      rd_run_q   <= '0;
      outst_q    <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wmask_q    <= '0;
      cmd_done_q <= 1'b0;
      wdf_done_q <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_run_q   <= rd_run_d;
      outst_q    <= outst_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wmask_q    <= wmask_d;
      cmd_done_q <= cmd_done_d;
      wdf_done_q <= wdf_done_d;
      rd_data_q  <= app_rd_data;
      rd_valid_q <= app_rd_data_valid;
    end
  end

`ifdef MIG_ARB_REFRESH_EN
  // Interval timer runs only once calibrated; a new period starts as the flag is raised.
  always_comb begin
    ref_cnt_d  = ref_cnt_q;
    ref_pend_d = ref_pend_q;
    if (ref_clr) ref_pend_d = 1'b0;
    if (state_q != INIT) begin
      if (ref_cnt_q == RW'(REF_INTERVAL - 1)) begin
        ref_cnt_d  = '0;
        ref_pend_d = 1'b1;
      end else begin
        ref_cnt_d = ref_cnt_q + RW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ref_cnt_q  <= '0;
      ref_pend_q <= 1'b0;
    end else begin
      ref_cnt_q  <= ref_cnt_d;
      ref_pend_q <= ref_pend_d;
    end
  end
`endif

  assign app_addr     = addr_q;
  assign app_wdf_data = wdata_q;
  assign app_wdf_mask = wmask_q;
  assign app_wdf_end  = app_wdf_wren;
  assign rd_data      = rd_data_q;
  assign rd_valid     = rd_valid_q;

endmodule

// File: tb/tb_mig_arbiter.sv
// Bench for mig_arbiter: vector table of single transactions plus multi-cycle sequences,
// with a small MIG read-return model feeding a read-data scoreboard.
module tb_mig_arbiter;
  localparam int AW = 28, DW = 128, MW = DW / 8, REF_IV = 50;

  logic clk = 1'b0, rst = 1'b0, init_calib_complete = 1'b0;
  logic rd_req = 1'b0, wr_req = 1'b0;
  logic [AW-1:0] rd_addr = '0, wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic [MW-1:0] wr_mask = '0;
  logic app_rdy = 1'b0, app_wdf_rdy = 1'b0, app_rd_data_valid = 1'b0, app_ref_ack = 1'b0;
  logic [DW-1:0] app_rd_data = '0;
  logic rd_ack, rd_valid, wr_ack, app_en, app_wdf_wren, app_wdf_end, app_ref_req;
  logic [DW-1:0] rd_data, app_wdf_data;
  logic [MW-1:0] app_wdf_mask;
  logic [AW-1:0] app_addr;
  logic [2:0] app_cmd;

  mig_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_RD_RUN(8), .MAX_OUTSTANDING(16),
                .REF_INTERVAL(REF_IV)) dut (
    .clk(clk), .rst(rst), .init_calib_complete(init_calib_complete),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_data(rd_data), .rd_valid(rd_valid),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_mask(wr_mask), .wr_ack(wr_ack),
    .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_wdf_data(app_wdf_data),
    .app_wdf_mask(app_wdf_mask), .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
    .app_rdy(app_rdy), .app_wdf_rdy(app_wdf_rdy), .app_rd_data(app_rd_data),
    .app_rd_data_valid(app_rd_data_valid), .app_ref_req(app_ref_req), .app_ref_ack(app_ref_ack));

  always #5 clk = ~clk;

  typedef struct {
    bit wr; logic [AW-1:0] addr; logic [DW-1:0] data; logic [MW-1:0] mask;
    int rdy_dly; int wdf_dly; int ack_cyc; logic [2:0] cmd;
  } vec_t;
  typedef struct { logic [DW-1:0] data; int due; } exp_t;

  vec_t vecs[7];
  exp_t exp_q[$];
  exp_t e;
  logic [AW-1:0] mig_q[$];
  bit ack_log[$];
  int n_cmp = 0, n_fail = 0, cyc = 0, n_rd_ack = 0, n_wr_ack = 0, ref_hi = 0, ref_wait = 0;
  bit ret_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] mkdata(input logic [AW-1:0] a);
    return {4{4'h9, a}};
  endfunction

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // MIG read-return model: hands back the oldest accepted read this cycle.
  task automatic ret_one();
    logic [AW-1:0] a;
    if (mig_q.size() > 0) begin
      a = mig_q.pop_front();
      app_rd_data_valid = 1'b1;
      app_rd_data = mkdata(a);
      exp_q.push_back('{data: mkdata(a), due: cyc + 1});
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
    app_rd_data_valid = 1'b0;
    if (ret_en) ret_one();
    app_ref_ack = 1'b0;
    if (app_ref_req) begin
      ref_wait++;
      if (ref_wait == 3) begin app_ref_ack = 1'b1; ref_wait = 0; end
    end else ref_wait = 0;
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (app_en && app_cmd == 3'b001 && app_rdy) mig_q.push_back(app_addr);
      if (rd_ack) begin n_rd_ack++; ack_log.push_back(1'b0); end
      if (wr_ack) begin n_wr_ack++; ack_log.push_back(1'b1); end
      if (app_ref_req) begin ref_hi++; chk("ref_no_app_en", app_en, 0); end
      if (rd_valid) begin
        chk("rd_beat_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("rd_data", rd_data, e.data);
          chk("rd_latency", cyc, e.due);
        end
      end
    end
  end

  task automatic run_vec(input vec_t v, input string nm);
    int g;
    logic ack;
    if (v.wr) begin wr_req = 1'b1; wr_addr = v.addr; wr_data = v.data; wr_mask = v.mask; end
    else begin rd_req = 1'b1; rd_addr = v.addr; end
    app_rdy = 1'b0; app_wdf_rdy = 1'b0;
    g = 0;
    while (!app_en && g < 20) begin tick(); g++; end
    chk({nm, ".grant"}, app_en, 1);
    wr_addr = ~v.addr; wr_data = ~v.data; wr_mask = ~v.mask; rd_addr = ~v.addr;
    for (int k = 0; k <= v.ack_cyc; k++) begin
      app_rdy = (k >= v.rdy_dly);
      app_wdf_rdy = v.wr && (k >= v.wdf_dly);
      if (k == v.ack_cyc) begin rd_req = 1'b0; wr_req = 1'b0; end
      #1;
      chk({nm, ".app_en"}, app_en, k <= v.rdy_dly);
      chk({nm, ".wren"}, app_wdf_wren, v.wr && k <= v.wdf_dly);
      chk({nm, ".wend"}, app_wdf_end, v.wr && k <= v.wdf_dly);
      ack = v.wr ? wr_ack : rd_ack;
      chk({nm, ".ack"}, ack, k == v.ack_cyc);
      if (app_en) begin
        chk({nm, ".cmd"}, app_cmd, v.cmd);
        chk({nm, ".addr"}, app_addr, v.addr);
      end
      if (app_wdf_wren) begin
        chk({nm, ".wdata"}, app_wdf_data, v.data);
        chk({nm, ".wmask"}, app_wdf_mask, v.mask);
      end
      tick();
    end
    app_rdy = 1'b0; app_wdf_rdy = 1'b0; #1;
    chk({nm, ".released"}, app_en | app_wdf_wren, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g, bad, w;
    vecs[0] = '{wr:0, addr:28'h0000100, data:'0, mask:'0, rdy_dly:0, wdf_dly:0, ack_cyc:0, cmd:3'b001};
    vecs[1] = '{wr:0, addr:28'hABCDEF0, data:'0, mask:'0, rdy_dly:3, wdf_dly:0, ack_cyc:3, cmd:3'b001};
    vecs[2] = '{wr:1, addr:28'h0000200, data:128'h0123456789ABCDEF_FEDCBA9876543210,
                mask:16'h0000, rdy_dly:0, wdf_dly:0, ack_cyc:0, cmd:3'b000};
    vecs[3] = '{wr:1, addr:28'h0FFFFFF, data:{DW{1'b1}}, mask:16'hFFFF,
                rdy_dly:2, wdf_dly:5, ack_cyc:5, cmd:3'b000};
    vecs[4] = '{wr:1, addr:28'h1234567, data:128'hCAFEF00D_00000000_DEADBEEF_12345678,
                mask:16'hA5A5, rdy_dly:4, wdf_dly:1, ack_cyc:4, cmd:3'b000};
    vecs[5] = '{wr:0, addr:28'hFFFFFFF, data:'0, mask:'0, rdy_dly:1, wdf_dly:0, ack_cyc:1, cmd:3'b001};
    vecs[6] = '{wr:1, addr:28'h0000000, data:128'h5555_AAAA, mask:16'h0F0F,
                rdy_dly:3, wdf_dly:3, ack_cyc:3, cmd:3'b000};

    // Reset with every input pushing for activity.
    #2 rst = 1'b1;
    rd_req = 1'b1; wr_req = 1'b1; init_calib_complete = 1'b1; app_rdy = 1'b1; app_wdf_rdy = 1'b1;
    app_rd_data_valid = 1'b1; app_rd_data = {DW{1'b1}};
    @(posedge clk); #1; @(posedge clk); #1;
    chk("rst.app_en", app_en, 0);
    chk("rst.wren", app_wdf_wren, 0);
    chk("rst.wend", app_wdf_end, 0);
    chk("rst.ref_req", app_ref_req, 0);
    chk("rst.rd_ack", rd_ack, 0);
    chk("rst.wr_ack", wr_ack, 0);
    chk("rst.rd_valid", rd_valid, 0);
    chk("rst.cmd", app_cmd, 0);
    chk("rst.addr", app_addr, 0);
    chk("rst.wdata", app_wdf_data, 0);
    chk("rst.wmask", app_wdf_mask, 0);
    chk("rst.rd_data", rd_data, 0);
    app_rd_data_valid = 1'b0; app_rd_data = '0; wr_req = 1'b0; app_rdy = 1'b0; app_wdf_rdy = 1'b0;
    init_calib_complete = 1'b0; rd_addr = 28'h0000050;
    rst = 1'b0;

    // Calibration hold-off, then first command within two cycles.
    bad = 0;
    repeat (100) begin tick(); if (app_en) bad++; end
    chk("calib_hold_app_en_cycles", bad, 0);
    init_calib_complete = 1'b1;
    g = 0;
    do begin tick(); g++; end while (!app_en && g < 5);
    chk("calib_first_en_cycles", g, 2);
    ret_en = 1'b1; app_rdy = 1'b1; #1;
    chk("calib_rd_ack", rd_ack, 1);
    rd_req = 1'b0;
    tick(); app_rdy = 1'b0;

    for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("v%0d", i));
    repeat (4) tick();

    // Both requesters saturating: eight reads then one write, repeating.
    ack_log.delete();
    rd_addr = 28'h0000ABC; wr_addr = 28'h0000DEF; wr_data = 128'h77; wr_mask = '0;
    rd_req = 1'b1; wr_req = 1'b1; app_rdy = 1'b1; app_wdf_rdy = 1'b1;
    repeat (54) tick();
    rd_req = 1'b0; wr_req = 1'b0;
    repeat (3) tick();
    app_rdy = 1'b0; app_wdf_rdy = 1'b0;
    chk("pattern_len_ok", ack_log.size() >= 18, 1);
    for (int i = 0; i < ack_log.size() && i < 27; i++)
      chk($sformatf("pattern[%0d]", i), ack_log[i], (i % 9) == 8);
    repeat (5) tick();

    // Outstanding-read limit.
    ret_en = 1'b0; n_rd_ack = 0;
    rd_addr = 28'h0000777; rd_req = 1'b1; app_rdy = 1'b1;
    repeat (40) tick();
    chk("outst_full_acks", n_rd_ack, 16);
    chk("outst_full_no_en", app_en, 0);
    n_rd_ack = 0;
    tick(); ret_one();
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (app_en && bad == 0) begin ret_one(); bad = 1; end
    end
    chk("outst_resume_acks", n_rd_ack, 2);
    chk("outst_refull_no_en", app_en, 0);
    rd_req = 1'b0; ret_en = 1'b1;
    repeat (25) tick();
    app_rdy = 1'b0;
    chk("outst_drained", mig_q.size(), 0);

    // Asynchronous reset in the middle of a write.
    wr_addr = 28'h0ABCDEF; wr_data = 128'hBEEF; wr_mask = 16'h0003; wr_req = 1'b1;
    g = 0;
    while (!app_en && g < 10) begin tick(); g++; end
    chk("rstwr.grant", app_en, 1);
    w = n_wr_ack;
    #1 rst = 1'b1; #1;
    chk("rstwr.app_en", app_en, 0);
    chk("rstwr.wren", app_wdf_wren, 0);
    chk("rstwr.wr_ack", wr_ack, 0);
    chk("rstwr.addr", app_addr, 0);
    chk("rstwr.wdata", app_wdf_data, 0);
    tick(); tick();
    rst = 1'b0;
    g = 0;
    do begin tick(); g++; end while (!app_en && g < 6);
    chk("rstwr.reissue_cycles", g, 2);
    chk("rstwr.no_ack_dropped", n_wr_ack, w);
    app_rdy = 1'b1; app_wdf_rdy = 1'b1; #1;
    chk("rstwr.reissue_ack", wr_ack, 1);
    wr_req = 1'b0;
    tick(); app_rdy = 1'b0; app_wdf_rdy = 1'b0;

`ifdef MIG_ARB_REFRESH_EN
    begin : ref_test
      int rise[$];
      bit prev;
      prev = 1'b0;
      for (int c = 0; c < 130; c++) begin
        tick();
        if (app_ref_req && !prev) rise.push_back(c);
        prev = app_ref_req;
      end
      chk("ref_seen", rise.size() >= 2, 1);
      for (int i = 1; i < rise.size(); i++) chk("ref_interval", rise[i] - rise[i-1], REF_IV);
    end
`else
    repeat (20) tick();
    chk("ref_tied_low_cycles", ref_hi, 0);
`endif

    repeat (5) tick();
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
